prog_loader: RTL

- Write-side counterpart to the CPU's instruction/data fetch path.
- Accepts a byte stream over a valid/ready handshake, packs bytes into 32-bit little-endian words, and writes them sequentially into program memory.
- Holds the CPU in reset until a complete, checksum-verified image is loaded, then releases it.
- Sits between the host byte link and the memory write port; its cpu_reset output drives the CPU's reset.

---
 rtl/prog_loader_pkg.sv | 23 ++
 rtl/prog_loader_byte_packer.sv | 50 +++++
 rtl/prog_loader.sv | 118 +++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// Shared loader definitions: state encodings and stream framing constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    HDR_LO = 3'd0,
    HDR_HI = 3'd1,
    DATA   = 3'd2,
    CSUM   = 3'd3,
    DONE   = 3'd4,
    ERROR  = 3'd5
  } ld_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_BYTES      = 2;

  // States in which the loader is still consuming stream bytes.
  function automatic logic is_loading(input ld_state_t s);
    return (s == HDR_LO) || (s == HDR_HI) || (s == DATA) || (s == CSUM);
  endfunction

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Packs bytes little-endian into 32-bit words (first byte lands in [7:0]).
// Latency: word_vld/word_dat registered, one cycle after the 4th byte.
// Backpressure: none; accepts a byte whenever byte_vld is high.
module byte_packer
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_vld,
  input  logic [7:0]  byte_dat,
  output logic        last_byte,
  output logic        word_vld,
  output logic [31:0] word_dat
);

  logic [1:0]  cnt;
  logic [23:0] shreg;

  // Next accepted byte completes the current word.
  assign last_byte = (cnt == 2'(BYTES_PER_WORD - 1));

  // Shift bytes in from the top so the oldest byte ends at the bottom.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      shreg    <= '0;
      word_vld <= 1'b0;
      word_dat <= '0;
    end else if (clear) begin
      cnt      <= '0;
      shreg    <= '0;
      word_vld <= 1'b0;
    end else begin
      word_vld <= 1'b0;
      if (byte_vld) begin
        if (last_byte) begin
          word_dat <= {byte_dat, shreg};
          word_vld <= 1'b1;
          shreg    <= '0;
          cnt      <= '0;
        end else begin
          shreg <= {byte_dat, shreg[23:8]};
          cnt   <= cnt + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Loads a framed, XOR-checked image into program memory and gates CPU reset.
// Latency: memory write one cycle after each word's 4th byte; status on the accepting edge.
// Backpressure: rx_ready high while loading, low once the image is done or rejected.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_reset,
  output logic                  load_done,
  output logic                  load_error
);

  localparam int CW = ADDR_WIDTH + 1;

  ld_state_t     state, state_nxt;
  logic [7:0]    hdr_lo;
  logic [7:0]    csum;
  logic [CW-1:0] n_words;
  logic [CW-1:0] word_idx;
  logic [15:0]   hdr_n;
  logic          accept;
  logic          hdr_bad;
  logic          last_word;
  logic          pk_last;
  logic          pk_vld;
  logic [31:0]   pk_word;

  assign accept    = rx_valid && rx_ready;
  assign hdr_n     = {rx_data, hdr_lo};
  // Zero-length or overflowing images are rejected so the address never wraps.
  assign hdr_bad   = (hdr_n == 16'd0) ||
                     ((32'(hdr_n) + 32'(BASE_ADDR)) > (32'd1 << ADDR_WIDTH));
  assign last_word = (word_idx == (n_words - CW'(1)));

  byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (state != DATA),
    .byte_vld  (accept && (state == DATA)),
    .byte_dat  (rx_data),
    .last_byte (pk_last),
    .word_vld  (pk_vld),
    .word_dat  (pk_word)
  );

  assign mem_we    = pk_vld;
  assign mem_wdata = pk_word;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= HDR_LO;
    else       state <= state_nxt;
  end

  // Next-state: advance only on an accepted byte.
  always_comb begin
    state_nxt = state;
    case (state)
      HDR_LO: if (accept) state_nxt = HDR_HI;
      HDR_HI: if (accept) state_nxt = hdr_bad ? ERROR : DATA;
      DATA:   if (accept && pk_last && last_word) state_nxt = CSUM;
      CSUM:   if (accept) state_nxt = (rx_data == csum) ? DONE : ERROR;
      DONE:   state_nxt = DONE;
      ERROR:  state_nxt = ERROR;
      default: state_nxt = ERROR;
    endcase
  end

  // Header capture, running XOR, word index and write address.
  always_ff @(posedge clk) begin
    if (reset) begin
      hdr_lo   <= '0;
      csum     <= '0;
      n_words  <= '0;
      word_idx <= '0;
      mem_addr <= '0;
    end else if (accept) begin
      case (state)
        HDR_LO: hdr_lo  <= rx_data;
        HDR_HI: n_words <= CW'(hdr_n);
        DATA: begin
          csum <= csum ^ rx_data;
          if (pk_last) begin
            mem_addr <= ADDR_WIDTH'(BASE_ADDR) + word_idx[ADDR_WIDTH-1:0];
            word_idx <= word_idx + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Status outputs follow the next state so cpu_reset and load_done move together.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_ready   <= 1'b0;
      cpu_reset  <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      rx_ready   <= is_loading(state_nxt);
      cpu_reset  <= (state_nxt != DONE);
      load_done  <= (state_nxt == DONE);
      load_error <= (state_nxt == ERROR);
    end
  end

endmodule
